// File: rtl/seg_scan_if.sv
// Digit-buffer write port, blank/blink controls and scan outputs of seg_scan_ctrl.
// AW defaults to $clog2(DIGITS); widen it to let out-of-range addresses reach the block.
interface seg_scan_if #(
  parameter int DIGITS = 8,
  parameter int AW     = $clog2(DIGITS)
);
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [7:0]           wr_data;
  logic                 blank_all;
  logic [DIGITS-1:0]    blink_mask;
  logic [7:0]           led_A_seg_Natural;
  logic [DIGITS-1:0]    digit_sel;
  logic                 frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, blank_all, blink_mask,
    input  led_A_seg_Natural, digit_sel, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, blank_all, blink_mask,
    output led_A_seg_Natural, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one blank cycle then SCAN_DIV-1 SHOW cycles per digit.
// Optional blink feature built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64,
  parameter int AW        = $clog2(DIGITS)
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);
  localparam int         CW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int         IW         = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] CODE_BLANK = 8'd34;
  localparam logic [0:0] ST_BLANK   = 1'b0;
  localparam logic [0:0] ST_SHOW    = 1'b1;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DIGITS-1:0][7:0]    buf_q;
  logic                      blank_q;
  logic [7:0]                led_q, led_d;
  logic [DIGITS-1:0]         sel_q, sel_d;
  logic                      tick_q, tick_d;
  logic [0:0]                st_d;
  logic                      slot_end;
  logic [31:0]               addr_w;
  logic                      addr_ok;
  logic                      blink_off;

  assign addr_w  = 32'(bus.wr_addr);
  assign addr_ok = addr_w < 32'(DIGITS);

  // Outputs are computed from next-state so they move on the same edge as cnt/idx.
  always_comb begin
    slot_end = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    st_d     = (cnt_d == '0) ? ST_BLANK : ST_SHOW;
    // cnt/idx only both reach zero through a wrap, never out of reset, so frame 0 has no tick.
    tick_d   = slot_end && (idx_d == '0);
    sel_d    = '0;
    led_d    = CODE_BLANK;
    if (st_d == ST_SHOW) begin
      sel_d[idx_d] = 1'b1;
      led_d        = (blank_q || blink_off) ? CODE_BLANK : buf_q[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      blank_q <= 1'b0;
      led_q   <= CODE_BLANK;
      sel_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blank_q <= bus.blank_all;
      led_q   <= led_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  // Codes are stored raw; anything above 36 is left for the decoder to handle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < DIGITS; g++) buf_q[g] <= CODE_BLANK;
    end else if (bus.wr_en && addr_ok) begin
      for (int g = 0; g < DIGITS; g++)
        if (addr_w == 32'(g)) buf_q[g] <= bus.wr_data;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_DIV + 1);

  logic [FW-1:0] fcnt_q;
  logic          phase_on_q;

  // Phase flips on the BLINK_DIV-th frame_tick; the tick slot itself is blank so no glitch shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q     <= '0;
      phase_on_q <= 1'b1;
    end else if (tick_d) begin
      if (fcnt_q == FW'(BLINK_DIV - 1)) begin
        fcnt_q     <= '0;
        phase_on_q <= !phase_on_q;
      end else begin
        fcnt_q     <= fcnt_q + FW'(1);
      end
    end
  end

  assign blink_off = !phase_on_q && bus.blink_mask[idx_d];
`else
  logic unused_blink;
  assign unused_blink = ^{bus.blink_mask, BLINK_DIV[0]};
  assign blink_off    = 1'b0;
`endif

  assign bus.led_A_seg_Natural = led_q;
  assign bus.digit_sel         = sel_q;
  assign bus.frame_tick        = tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Random + directed bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;
  localparam int         D    = 4;
  localparam int         S    = 4;
  localparam int         B    = 2;
  localparam int         AW   = 3;
  localparam logic [3:0] MASK = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(D), .AW(AW)) bus();

  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(B), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;
  int mbuf[D];
  int bsamp;
  int exp_code, exp_sel, exp_tick;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, act, exp, k);
    end
  endtask

  // Expected outputs after k edges since reset, from frame position alone.
  function automatic void model_out();
    int pos  = k % (D * S);
    int slot = pos / S;
    int c    = pos % S;
    int fr   = k / (D * S);
    bit off  = 1'b0;
    exp_tick = (pos == 0 && k > 0) ? 1 : 0;
    if (c == 0) begin
      exp_sel  = 0;
      exp_code = 34;
    end else begin
      exp_sel = 1 << slot;
`ifdef SEG_SCAN_BLINK_EN
      off = MASK[slot] && ((fr / B) % 2 == 1);
`else
      off = (fr < 0);
`endif
      exp_code = (bsamp != 0 || off) ? 34 : mbuf[slot];
    end
  endfunction

  task automatic cycle(input bit we, input int addr, input int data, input bit blank);
    bus.wr_en     = we;
    bus.wr_addr   = addr[AW-1:0];
    bus.wr_data   = data[7:0];
    bus.blank_all = blank;
    @(posedge clk);
    k++;
    model_out();
    if (we && addr < D) mbuf[addr] = data & 255;
    bsamp = blank;
    @(negedge clk);
    chk("code", bus.led_A_seg_Natural, exp_code);
    chk("sel", bus.digit_sel, exp_sel);
    chk("tick", bus.frame_tick, exp_tick);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    bus.wr_en     = 1'b0;
    bus.blank_all = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_code", bus.led_A_seg_Natural, 34);
    chk("rst_sel", bus.digit_sel, 0);
    chk("rst_tick", bus.frame_tick, 0);
    for (int i = 0; i < D; i++) mbuf[i] = 34;
    k     = 0;
    bsamp = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic seek(input int slot, input int c);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * D * S && !hit; i++) begin
      if ((k % S) == c && ((k % (D * S)) / S) == slot) hit = 1'b1;
      else cycle(0, 0, 0, 0);
    end
    chk("seek", hit, 1);
  endtask

  initial begin
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.blank_all  = 1'b0;
    bus.blink_mask = MASK;
    do_reset();

    for (int i = 0; i < D; i++) cycle(1, i, i + 1, 0);
    idle(3 * D * S);

    // Overwrite the shown digit mid-SHOW; new code must appear one cycle later.
    seek(2, 1);
    cycle(1, 2, 36, 0);
    cycle(0, 0, 0, 0);
    chk("wr36", bus.led_A_seg_Natural, 36);
    cycle(1, 5, 99, 0);
    idle(D * S);

    repeat (6) cycle(0, 0, 0, 1);
    idle(D * S);

    repeat (600)
      cycle(($urandom % 4) == 0, $urandom_range(0, 5), $urandom_range(0, 40), ($urandom % 8) == 0);

    seek(2, 2);
    chk("pre_rst_sel", bus.digit_sel, 4);
    do_reset();
    idle(2 * D * S);

    for (int i = 0; i < D; i++) cycle(1, i, 10 + i, 0);
    idle(8 * D * S);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
